// File: rtl/vga_cfg_sequencer.sv
// AXI4-Lite master that writes the vga_ipp slave registers from one parallel word per start pulse.
// Define VGA_CFG_READBACK_EN to read back and compare every register after it is written.
module vga_cfg_sequencer #(
    parameter logic [31:0] C_BASE_ADDR = 32'h0000_0000,
    parameter int          C_NUM_REGS  = 4,
    parameter int          C_TIMEOUT   = 255
) (
    input  logic         ACLK,
    input  logic         ARESETN,
    input  logic         start,
    input  logic [127:0] cfg_data,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [1:0]   err_code,
    output logic [1:0]   err_idx,
    output logic [31:0]  m_axi_awaddr,
    output logic [2:0]   m_axi_awprot,
    output logic         m_axi_awvalid,
    input  logic         m_axi_awready,
    output logic [31:0]  m_axi_wdata,
    output logic [3:0]   m_axi_wstrb,
    output logic         m_axi_wvalid,
    input  logic         m_axi_wready,
    input  logic [1:0]   m_axi_bresp,
    input  logic         m_axi_bvalid,
    output logic         m_axi_bready,
    output logic [31:0]  m_axi_araddr,
    output logic [2:0]   m_axi_arprot,
    output logic         m_axi_arvalid,
    input  logic         m_axi_arready,
    input  logic [31:0]  m_axi_rdata,
    input  logic [1:0]   m_axi_rresp,
    input  logic         m_axi_rvalid,
    output logic         m_axi_rready
);
    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RRESP, NEXT} state_t;

    localparam logic [1:0] LAST_IDX     = 2'(C_NUM_REGS - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(C_TIMEOUT - 1);
    localparam logic [1:0] CODE_RESP    = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b11;

    state_t       state, next_state;
    logic [127:0] snapshot;
    logic [1:0]   idx;
    logic [7:0]   phase_cnt;
    logic         aw_done, w_done;
    logic         accept, abort, last, timed_out, aw_ok, w_ok;
    logic [1:0]   abort_code;
    logic [31:0]  cur_data, cur_addr;

    assign last      = (idx == LAST_IDX);
    assign timed_out = (phase_cnt == TIMEOUT_LAST);
    assign cur_data  = snapshot[{idx, 5'b00000} +: 32];
    assign cur_addr  = C_BASE_ADDR + {28'd0, idx, 2'b00};
    assign aw_ok     = aw_done || m_axi_awready;
    assign w_ok      = w_done || m_axi_wready;

    // busy already drops in the done cycle, so a start there is accepted and chains a new sequence
    assign done   = (state == NEXT) && last;
    assign busy   = (state != IDLE) && !done;
    assign accept = start && !busy;

    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_awvalid = (state == WADDR) && !aw_done;
    assign m_axi_wvalid  = (state == WADDR) && !w_done;
    assign m_axi_awaddr  = (state == WADDR) ? cur_addr : 32'h0;
    assign m_axi_wdata   = (state == WADDR) ? cur_data : 32'h0;
    assign m_axi_bready  = (state == WRESP);

`ifdef VGA_CFG_READBACK_EN
    assign m_axi_arvalid = (state == RADDR);
    assign m_axi_araddr  = (state == RADDR) ? cur_addr : 32'h0;
    assign m_axi_rready  = (state == RRESP);
`else
    logic unused_readback;
    assign unused_readback = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid};
    assign m_axi_arvalid   = 1'b0;
    assign m_axi_araddr    = 32'h0;
    assign m_axi_rready    = 1'b0;
`endif

    always_comb begin
        next_state = state;
        abort      = 1'b0;
        abort_code = 2'b00;
        case (state)
            IDLE:  if (start) next_state = WADDR;
            WADDR: begin
                if (aw_ok && w_ok) next_state = WRESP;
                else if (timed_out) begin abort = 1'b1; abort_code = CODE_TIMEOUT; end
            end
            WRESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin abort = 1'b1; abort_code = CODE_RESP; end
`ifdef VGA_CFG_READBACK_EN
                    else next_state = RADDR;
`else
                    else next_state = NEXT;
`endif
                end else if (timed_out) begin
                    abort = 1'b1; abort_code = CODE_TIMEOUT;
                end
            end
`ifdef VGA_CFG_READBACK_EN
            RADDR: begin
                if (m_axi_arready) next_state = RRESP;
                else if (timed_out) begin abort = 1'b1; abort_code = CODE_TIMEOUT; end
            end
            RRESP: begin
                if (m_axi_rvalid) begin
                    if (m_axi_rresp != 2'b00) begin abort = 1'b1; abort_code = CODE_RESP; end
                    else if (m_axi_rdata != cur_data) begin abort = 1'b1; abort_code = 2'b10; end
                    else next_state = NEXT;
                end else if (timed_out) begin
                    abort = 1'b1; abort_code = CODE_TIMEOUT;
                end
            end
`endif
            NEXT:    next_state = (!last || start) ? WADDR : IDLE;
            default: next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end

    // The phase counter restarts on every state change so each AXI phase gets its own budget
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            phase_cnt <= 8'd0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            state     <= next_state;
            phase_cnt <= (next_state != state || state == IDLE) ? 8'd0 : phase_cnt + 8'd1;
            aw_done   <= (state == WADDR) && (next_state == WADDR) && aw_ok;
            w_done    <= (state == WADDR) && (next_state == WADDR) && w_ok;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            snapshot <= 128'd0;
            idx      <= 2'd0;
            err      <= 1'b0;
            err_code <= 2'b00;
            err_idx  <= 2'd0;
        end else begin
            if (accept) begin
                snapshot <= cfg_data;
                idx      <= 2'd0;
                err      <= 1'b0;
                err_code <= 2'b00;
                err_idx  <= 2'd0;
            end else if (state == NEXT && !last) begin
                idx <= idx + 2'd1;
            end
            if (abort) begin
                err      <= 1'b1;
                err_code <= abort_code;
                err_idx  <= idx;
            end
        end
    end
endmodule

// File: tb/tb_vga_cfg_sequencer.sv
// Directed bench for vga_cfg_sequencer with a small AXI4-Lite slave model and per-scenario tasks.
// Expectations follow VGA_CFG_READBACK_EN so the same bench covers both builds.
`timescale 1ns/1ps
module tb_vga_cfg_sequencer;
    localparam logic [31:0] BASE = 32'h44A0_0000;
    localparam int NREG = 4;
    localparam int TMO  = 16;
`ifdef VGA_CFG_READBACK_EN
    localparam int PER_REG = 5;
    localparam int EXP_RD  = 4;
`else
    localparam int PER_REG = 3;
    localparam int EXP_RD  = 0;
`endif
    localparam logic [127:0] CFG_A = {32'h0101_FFFF, 32'hABCD_0001, 32'hDEAD_0011, 32'hBEEF_0011};
    localparam logic [127:0] CFG_B = {32'h0000_0001, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'h1234_5678};

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic         start = 1'b0;
    logic [127:0] cfg_data = '0;
    logic         busy, done, err;
    logic [1:0]   err_code, err_idx;
    logic [31:0]  m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]   m_axi_awprot, m_axi_arprot;
    logic [3:0]   m_axi_wstrb;
    logic         m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [1:0]   m_axi_bresp, m_axi_rresp;
    logic         m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic         m_axi_rvalid, m_axi_rready;

    int checks = 0;
    int failures = 0;

    int   w_delay = 0;
    int   bad_b_idx = -1;
    int   bad_r_idx = -1;
    logic no_awready = 1'b0;

    int          wvalid_age;
    logic        b_pend, r_pend, got_aw, got_w;
    logic [31:0] held_a, held_d, r_a;
    logic [31:0] mem [4];
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          aw_cnt = 0;

    vga_cfg_sequencer #(.C_BASE_ADDR(BASE), .C_NUM_REGS(NREG), .C_TIMEOUT(TMO)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_data(cfg_data),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .err_idx(err_idx),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 ACLK = ~ACLK;

    // Slave model: responses follow the handshakes one cycle later, like a zero-wait AXI-Lite slave
    logic        aw_hs, w_hs;
    logic [31:0] a_cur, d_cur;
    assign aw_hs         = m_axi_awvalid && m_axi_awready;
    assign w_hs          = m_axi_wvalid && m_axi_wready;
    assign a_cur         = aw_hs ? m_axi_awaddr : held_a;
    assign d_cur         = w_hs ? m_axi_wdata : held_d;
    assign m_axi_awready = !no_awready;
    assign m_axi_wready  = (wvalid_age >= w_delay);
    assign m_axi_bvalid  = b_pend;
    assign m_axi_bresp   = (b_pend && bad_b_idx == int'(held_a[3:2])) ? 2'b10 : 2'b00;
    assign m_axi_arready = 1'b1;
    assign m_axi_rvalid  = r_pend;
    assign m_axi_rresp   = 2'b00;
    assign m_axi_rdata   = (bad_r_idx == int'(r_a[3:2])) ? 32'h0 : mem[r_a[3:2]];

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            b_pend <= 1'b0; r_pend <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0; wvalid_age <= 0;
        end else begin
            wvalid_age <= (m_axi_wvalid && !m_axi_wready) ? wvalid_age + 1 : 0;
            if (aw_hs) begin held_a <= m_axi_awaddr; got_aw <= 1'b1; aw_cnt <= aw_cnt + 1; end
            if (w_hs) begin held_d <= m_axi_wdata; got_w <= 1'b1; end
            if ((got_aw || aw_hs) && (got_w || w_hs)) begin
                got_aw <= 1'b0; got_w <= 1'b0; b_pend <= 1'b1;
                mem[a_cur[3:2]] <= d_cur;
                if (wr_cnt < 64) begin wr_addr[wr_cnt] <= a_cur; wr_data[wr_cnt] <= d_cur; end
                wr_cnt <= wr_cnt + 1;
            end
            if (b_pend && m_axi_bready) b_pend <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) begin r_a <= m_axi_araddr; r_pend <= 1'b1; rd_cnt <= rd_cnt + 1; end
            if (r_pend && m_axi_rready) r_pend <= 1'b0;
        end
    end

    function automatic logic [31:0] word_of(input logic [127:0] cfg, input int i);
        return cfg[i*32 +: 32];
    endfunction

    // Leaves the caller at the sample point of the cycle after start, i.e. t+1
    task automatic pulse_start(input logic [127:0] cfg);
        start = 1'b1; cfg_data = cfg;
        @(negedge ACLK);
        start = 1'b0; cfg_data = '0;
    endtask

    // Current cycle counts as 1; returns the first done cycle and the first cycle busy is low (-1 if none)
    task automatic wait_end(input int budget, output int done_cyc, output int end_cyc);
        done_cyc = -1; end_cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            if (c > 1) @(negedge ACLK);
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            if (busy !== 1'b1) begin end_cyc = c; break; end
        end
    endtask

    task automatic reset_pulse();
        ARESETN = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        repeat (2) @(negedge ACLK);
        checks++;
        if ({busy, done, err, err_code, err_idx} !== 7'd0) begin
            failures++; $display("[TB] FAIL reset_status got %b want 0000000", {busy, done, err, err_code, err_idx});
        end
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'd0) begin
            failures++; $display("[TB] FAIL reset_handshake got %b want 00000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
        end
        checks++;
        if ({m_axi_awaddr, m_axi_wdata, m_axi_araddr} !== 96'd0) begin
            failures++; $display("[TB] FAIL reset_addr_data got %h %h %h want 0", m_axi_awaddr, m_axi_wdata, m_axi_araddr);
        end
        checks++;
        if ({m_axi_wstrb, m_axi_awprot, m_axi_arprot} !== {4'hF, 6'd0}) begin
            failures++; $display("[TB] FAIL reset_strb_prot got %h %h %h want f 0 0", m_axi_wstrb, m_axi_awprot, m_axi_arprot);
        end
        ARESETN = 1'b1;
        @(negedge ACLK);
    endtask

    task automatic test_sequence();
        int wb, rb, dc, ec;
        wb = wr_cnt; rb = rd_cnt;
        pulse_start(CFG_A);
        checks++;
        if ({busy, m_axi_awvalid, m_axi_wvalid} !== 3'b111) begin
            failures++; $display("[TB] FAIL seq_first_cycle got %b want 111", {busy, m_axi_awvalid, m_axi_wvalid});
        end
        checks++;
        if (m_axi_awaddr !== BASE || m_axi_wdata !== 32'hBEEF_0011) begin
            failures++; $display("[TB] FAIL seq_first_beat got %h/%h want %h/beef0011", m_axi_awaddr, m_axi_wdata, BASE);
        end
        wait_end(60, dc, ec);
        checks++;
        if (dc !== NREG*PER_REG || ec !== NREG*PER_REG) begin
            failures++; $display("[TB] FAIL seq_done_cycle got done=%0d idle=%0d want %0d", dc, ec, NREG*PER_REG);
        end
        checks++;
        if (err !== 1'b0) begin failures++; $display("[TB] FAIL seq_err got %b want 0", err); end
        @(negedge ACLK);
        checks++;
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL seq_done_width got %b want 0", done); end
        checks++;
        if (wr_cnt - wb !== NREG || rd_cnt - rb !== EXP_RD) begin
            failures++; $display("[TB] FAIL seq_counts got wr=%0d rd=%0d want %0d %0d", wr_cnt - wb, rd_cnt - rb, NREG, EXP_RD);
        end
        for (int i = 0; i < NREG; i++) begin
            checks++;
            if (wr_addr[wb+i] !== BASE + 32'(4*i) || wr_data[wb+i] !== word_of(CFG_A, i)) begin
                failures++; $display("[TB] FAIL seq_write%0d got %h=%h want %h=%h", i, wr_addr[wb+i], wr_data[wb+i],
                    BASE + 32'(4*i), word_of(CFG_A, i));
            end
        end
    endtask

    task automatic test_wready_delay();
        int wb, dc, ec;
        wb = wr_cnt; w_delay = 3;
        pulse_start(CFG_B);
        @(negedge ACLK);
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid} !== 2'b01) begin
            failures++; $display("[TB] FAIL delay_aw_first got aw=%b w=%b want 0 1", m_axi_awvalid, m_axi_wvalid);
        end
        @(negedge ACLK);
        checks++;
        if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== word_of(CFG_B, 0)) begin
            failures++; $display("[TB] FAIL delay_w_held got %b/%h want 1/%h", m_axi_wvalid, m_axi_wdata, word_of(CFG_B, 0));
        end
        wait_end(80, dc, ec);
        checks++;
        if (dc !== NREG*(PER_REG+3) - 2 || err !== 1'b0) begin
            failures++; $display("[TB] FAIL delay_done got done=%0d err=%b want %0d 0", dc, err, NREG*(PER_REG+3) - 2);
        end
        for (int i = 0; i < NREG; i++) begin
            checks++;
            if (wr_data[wb+i] !== word_of(CFG_B, i)) begin
                failures++; $display("[TB] FAIL delay_write%0d got %h want %h", i, wr_data[wb+i], word_of(CFG_B, i));
            end
        end
        w_delay = 0;
        @(negedge ACLK);
    endtask

    task automatic test_bresp_error();
        int awb, dc, ec;
        awb = aw_cnt; bad_b_idx = 2;
        pulse_start(CFG_A);
        wait_end(60, dc, ec);
        checks++;
        if (ec !== 2*PER_REG + 3 || dc !== -1) begin
            failures++; $display("[TB] FAIL bresp_end got idle=%0d done=%0d want %0d -1", ec, dc, 2*PER_REG + 3);
        end
        checks++;
        if ({err, err_code, err_idx} !== {1'b1, 2'b01, 2'd2}) begin
            failures++; $display("[TB] FAIL bresp_err got %b %b %0d want 1 01 2", err, err_code, err_idx);
        end
        repeat (3) @(negedge ACLK);
        checks++;
        if (aw_cnt - awb !== 3 || m_axi_awvalid !== 1'b0 || err !== 1'b1) begin
            failures++; $display("[TB] FAIL bresp_no_fourth got aw=%0d awvalid=%b err=%b want 3 0 1", aw_cnt - awb, m_axi_awvalid, err);
        end
        bad_b_idx = -1;
        pulse_start(CFG_B);
        checks++;
        if (err !== 1'b0 || err_code !== 2'b00) begin
            failures++; $display("[TB] FAIL bresp_err_clear got %b %b want 0 00", err, err_code);
        end
        wait_end(60, dc, ec);
        checks++;
        if (dc !== NREG*PER_REG || err !== 1'b0) begin
            failures++; $display("[TB] FAIL bresp_recover got done=%0d err=%b want %0d 0", dc, err, NREG*PER_REG);
        end
        @(negedge ACLK);
    endtask

`ifdef VGA_CFG_READBACK_EN
    task automatic test_readback_mismatch();
        int dc, ec;
        bad_r_idx = 1;
        pulse_start(CFG_A);
        wait_end(60, dc, ec);
        checks++;
        if (ec !== PER_REG + 5 || dc !== -1 || {err, err_code, err_idx} !== {1'b1, 2'b10, 2'd1}) begin
            failures++; $display("[TB] FAIL rb_mismatch got idle=%0d done=%0d err=%b %b %0d want %0d -1 1 10 1",
                ec, dc, err, err_code, err_idx, PER_REG + 5);
        end
        bad_r_idx = -1;
        @(negedge ACLK);
        pulse_start(CFG_B);
        checks++;
        if (err !== 1'b0) begin failures++; $display("[TB] FAIL rb_err_clear got %b want 0", err); end
        wait_end(60, dc, ec);
        checks++;
        if (dc !== NREG*PER_REG || err !== 1'b0) begin
            failures++; $display("[TB] FAIL rb_recover got done=%0d err=%b want %0d 0", dc, err, NREG*PER_REG);
        end
        @(negedge ACLK);
    endtask
`endif

    task automatic test_timeout();
        no_awready = 1'b1;
        pulse_start(CFG_A);
        for (int c = 1; c <= TMO + 1; c++) begin
            if (c > 1) @(negedge ACLK);
            start = (c == 3);
            cfg_data = (c == 3) ? CFG_B : '0;
            if (c == TMO) begin
                checks++;
                if ({busy, m_axi_awvalid} !== 2'b11 || m_axi_wdata !== word_of(CFG_A, 0)) begin
                    failures++; $display("[TB] FAIL timeout_last_wait got busy=%b aw=%b data=%h want 1 1 %h",
                        busy, m_axi_awvalid, m_axi_wdata, word_of(CFG_A, 0));
                end
            end
            if (done === 1'b1) begin
                checks++; failures++; $display("[TB] FAIL timeout_done got 1 want 0 at cycle %0d", c);
            end
        end
        checks++;
        if (busy !== 1'b0 || {err, err_code, err_idx} !== {1'b1, 2'b11, 2'd0}) begin
            failures++; $display("[TB] FAIL timeout_abort got busy=%b err=%b %b %0d want 0 1 11 0", busy, err, err_code, err_idx);
        end
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'd0) begin
            failures++; $display("[TB] FAIL timeout_valids got %b want 00000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
        end
        no_awready = 1'b0;
        reset_pulse();
    endtask

    task automatic test_async_reset();
        int dc, ec;
        pulse_start(CFG_A);
        repeat (PER_REG + 1) @(negedge ACLK);
        checks++;
        if (m_axi_bready !== 1'b1) begin failures++; $display("[TB] FAIL areset_in_wresp got %b want 1", m_axi_bready); end
        #2 ARESETN = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 8'd0
            || m_axi_awaddr !== 32'h0 || m_axi_wdata !== 32'h0) begin
            failures++; $display("[TB] FAIL areset_outputs got %b %h %h want 0",
                {busy, done, err, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready},
                m_axi_awaddr, m_axi_wdata);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        pulse_start(CFG_B);
        checks++;
        if (m_axi_awaddr !== BASE || m_axi_wdata !== word_of(CFG_B, 0)) begin
            failures++; $display("[TB] FAIL areset_restart got %h/%h want %h/%h", m_axi_awaddr, m_axi_wdata, BASE, word_of(CFG_B, 0));
        end
        wait_end(60, dc, ec);
        checks++;
        if (dc !== NREG*PER_REG || err !== 1'b0) begin
            failures++; $display("[TB] FAIL areset_complete got done=%0d err=%b want %0d 0", dc, err, NREG*PER_REG);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_sequence();
        test_wready_delay();
        test_bresp_error();
`ifdef VGA_CFG_READBACK_EN
        test_readback_mismatch();
`endif
        test_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
